// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target serving a pointer-addressed byte register bank
// Optional input glitch filter on SCL/SDA: define I2C_INPUT_FILTER_EN (length FILTER_LEN).
module i2c_target_regfile #(
    parameter logic [6:0] DEV_ADDR   = 7'h50,
    parameter int         NUM_REGS   = 16,
    parameter int         FILTER_LEN = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i2c_scl_i,
    output logic                        i2c_scl_o,
    output logic                        i2c_scl_t,
    input  logic                        i2c_sda_i,
    output logic                        i2c_sda_o,
    output logic                        i2c_sda_t,
    output logic [NUM_REGS*8-1:0]       regs_flat,
    output logic                        wr_strobe,
    output logic [$clog2(NUM_REGS)-1:0] wr_addr,
    output logic                        busy
);
    localparam int PW = $clog2(NUM_REGS);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_WR_DATA,
        S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
    } state_t;

    logic scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d;
    logic sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d;
    logic scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    logic scl_f, sda_f;

`ifdef I2C_INPUT_FILTER_EN
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    logic [CW-1:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
    logic          scl_flt_q, scl_flt_d, sda_flt_q, sda_flt_d;

    // A new level is accepted only after FILTER_LEN consecutive differing samples.
    always_comb begin
        scl_flt_d = scl_flt_q;
        scl_cnt_d = '0;
        sda_flt_d = sda_flt_q;
        sda_cnt_d = '0;
        if (scl_s2_q != scl_flt_q) begin
            if (scl_cnt_q == CW'(FILTER_LEN - 1)) scl_flt_d = scl_s2_q;
            else                                  scl_cnt_d = scl_cnt_q + 1'b1;
        end
        if (sda_s2_q != sda_flt_q) begin
            if (sda_cnt_q == CW'(FILTER_LEN - 1)) sda_flt_d = sda_s2_q;
            else                                  sda_cnt_d = sda_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_cnt_q <= '0;
            sda_cnt_q <= '0;
            scl_flt_q <= 1'b1;
            sda_flt_q <= 1'b1;
        end else begin
            scl_cnt_q <= scl_cnt_d;
            sda_cnt_q <= sda_cnt_d;
            scl_flt_q <= scl_flt_d;
            sda_flt_q <= sda_flt_d;
        end
    end

    assign scl_f = scl_flt_q;
    assign sda_f = sda_flt_q;
`else
    logic unused_filter_len;
    assign unused_filter_len = (FILTER_LEN != 0);
    assign scl_f = scl_s2_q;
    assign sda_f = sda_s2_q;
`endif

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_f & ~scl_prev_q;
    assign scl_fall  = ~scl_f & scl_prev_q;
    assign start_det = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
    assign stop_det  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;

    state_t        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [6:0]    rx_q, rx_d;
    logic [6:0]    tx_q, tx_d;
    logic          rw_q, rw_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          sda_t_q, sda_t_d;
    logic          wr_strobe_q, wr_strobe_d;
    logic [PW-1:0] wr_addr_q, wr_addr_d;
    logic          busy_q, busy_d;
    logic [7:0]    regs_q [NUM_REGS];
    logic [7:0]    regs_d [NUM_REGS];

    logic [7:0] rx_byte, rd_byte;
    assign rx_byte = {rx_q, sda_f};
    assign rd_byte = regs_q[ptr_q];

    always_comb begin
        scl_s1_d    = i2c_scl_i;
        scl_s2_d    = scl_s1_q;
        sda_s1_d    = i2c_sda_i;
        sda_s2_d    = sda_s1_q;
        scl_prev_d  = scl_f;
        sda_prev_d  = sda_f;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        rw_d        = rw_q;
        ptr_d       = ptr_q;
        sda_t_d     = sda_t_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        busy_d      = busy_q;
        regs_d      = regs_q;

        if (stop_det) begin
            state_d   = S_IDLE;
            sda_t_d   = 1'b1;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
        end else if (start_det) begin
            state_d   = S_ADDR;
            sda_t_d   = 1'b1;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                S_ADDR, S_PTR, S_WR_DATA: begin
                    if (scl_rise) begin
                        rx_d      = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = '0;
                            if (state_q == S_ADDR) begin
                                if (rx_byte[7:1] == DEV_ADDR) begin
                                    state_d = S_ADDR_ACK;
                                    rw_d    = rx_byte[0];
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = S_IGNORE;
                                    busy_d  = 1'b0;
                                end
                            end else if (state_q == S_PTR) begin
                                ptr_d   = rx_byte[PW-1:0];
                                state_d = S_WR_ACK;
                            end else begin
                                regs_d[ptr_q] = rx_byte;
                                wr_addr_d     = ptr_q;
                                wr_strobe_d   = 1'b1;
                                ptr_d         = ptr_q + 1'b1;
                                state_d       = S_WR_ACK;
                            end
                        end
                    end
                end
                // bit_cnt marks whether the ninth rising edge has been seen yet.
                S_ADDR_ACK, S_WR_ACK: begin
                    if (scl_rise) begin
                        bit_cnt_d = 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            sda_t_d = 1'b0;
                        end else begin
                            bit_cnt_d = '0;
                            if (state_q == S_ADDR_ACK && rw_q) begin
                                state_d = S_RD_DATA;
                                sda_t_d = rd_byte[7];
                                tx_d    = rd_byte[6:0];
                            end else begin
                                sda_t_d = 1'b1;
                                state_d = (state_q == S_ADDR_ACK) ? S_PTR : S_WR_DATA;
                            end
                        end
                    end
                end
                S_RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_t_d   = 1'b1;
                            bit_cnt_d = '0;
                            state_d   = S_RD_ACK;
                        end else begin
                            sda_t_d = tx_q[6];
                            tx_d    = {tx_q[5:0], 1'b0};
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        ptr_d = ptr_q + 1'b1;
                        if (sda_f) state_d = S_IGNORE;
                        else       bit_cnt_d = 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        bit_cnt_d = '0;
                        state_d   = S_RD_DATA;
                        sda_t_d   = rd_byte[7];
                        tx_d      = rd_byte[6:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1_q    <= 1'b1;
            scl_s2_q    <= 1'b1;
            sda_s1_q    <= 1'b1;
            sda_s2_q    <= 1'b1;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            rw_q        <= 1'b0;
            ptr_q       <= '0;
            sda_t_q     <= 1'b1;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            busy_q      <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= 8'h00;
        end else begin
            scl_s1_q    <= scl_s1_d;
            scl_s2_q    <= scl_s2_d;
            sda_s1_q    <= sda_s1_d;
            sda_s2_q    <= sda_s2_d;
            scl_prev_q  <= scl_prev_d;
            sda_prev_q  <= sda_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            rw_q        <= rw_d;
            ptr_q       <= ptr_d;
            sda_t_q     <= sda_t_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            busy_q      <= busy_d;
            regs_q      <= regs_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = regs_q[g];
    end

    assign i2c_scl_o = 1'b0;
    assign i2c_scl_t = 1'b1;
    assign i2c_sda_o = 1'b0;
    assign i2c_sda_t = sda_t_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb/tb_i2c_target_regfile.sv - directed bench for i2c_target_regfile acting as I2C master
`timescale 1ns/1ps
module tb_i2c_target_regfile;
    localparam int H = 16;
    localparam int Q = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         scl_m = 1'b1;
    logic         sda_m = 1'b1;
    logic         i2c_scl_i, i2c_scl_o, i2c_scl_t;
    logic         i2c_sda_i, i2c_sda_o, i2c_sda_t;
    logic [127:0] regs_flat;
    logic         wr_strobe;
    logic [3:0]   wr_addr;
    logic         busy;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign i2c_scl_i = scl_m & (i2c_scl_t | i2c_scl_o);
    assign i2c_sda_i = sda_m & (i2c_sda_t | i2c_sda_o);

    i2c_target_regfile #(
        .DEV_ADDR  (7'h50),
        .NUM_REGS  (16),
        .FILTER_LEN(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i2c_scl_i(i2c_scl_i),
        .i2c_scl_o(i2c_scl_o),
        .i2c_scl_t(i2c_scl_t),
        .i2c_sda_i(i2c_sda_i),
        .i2c_sda_o(i2c_sda_o),
        .i2c_sda_t(i2c_sda_t),
        .regs_flat(regs_flat),
        .wr_strobe(wr_strobe),
        .wr_addr  (wr_addr),
        .busy     (busy)
    );

    int         stb_cnt = 0;
    int         low_cnt = 0;
    logic [3:0] stb_addr [64];

    always @(negedge clk) begin
        if (wr_strobe) begin
            stb_addr[stb_cnt % 64] = wr_addr;
            stb_cnt++;
        end
        if (!i2c_sda_t) low_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] reg_of(input int k);
        return regs_flat[8*k +: 8];
    endfunction

    task automatic i2c_start();
        wait_clk(Q); sda_m = 1'b1; wait_clk(Q); scl_m = 1'b1; wait_clk(H);
        sda_m = 1'b0; wait_clk(H); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(Q); sda_m = 1'b0; wait_clk(Q); scl_m = 1'b1; wait_clk(H);
        sda_m = 1'b1; wait_clk(H);
    endtask

    task automatic write_bit(input logic b, input logic glitch);
        wait_clk(Q); sda_m = b; wait_clk(Q); scl_m = 1'b1;
        if (glitch) begin
            wait_clk(4); scl_m = 1'b0; wait_clk(2); scl_m = 1'b1; wait_clk(H - 6);
        end else begin
            wait_clk(H);
        end
        scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i], glitch_bit == i);
        wait_clk(Q); sda_m = 1'b1; wait_clk(Q); scl_m = 1'b1;
        wait_clk(H / 2); ack = ~i2c_sda_i; wait_clk(H / 2); scl_m = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input string nm);
        logic ack;
        write_byte(b, -1, ack);
        check(nm, ack, 1'b1);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            wait_clk(Q); sda_m = 1'b1; wait_clk(Q); scl_m = 1'b1;
            wait_clk(H / 2); d[i] = i2c_sda_i; wait_clk(H / 2); scl_m = 1'b0;
        end
        wait_clk(Q); sda_m = nack; wait_clk(Q); scl_m = 1'b1; wait_clk(H); scl_m = 1'b0;
    endtask

    typedef struct {
        logic [7:0] ptr;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [3:0] a0;
        logic [3:0] a1;
    } vec_t;

    vec_t vt [4];

    initial begin
        int         base;
        int         lbase;
        logic       ack;
        logic [7:0] r0, r1, r2;

        vt[0] = '{8'h03, 8'hA5, 8'h5A, 4'd3,  4'd4};
        vt[1] = '{8'h0F, 8'h11, 8'h22, 4'd15, 4'd0};
        vt[2] = '{8'h05, 8'h3E, 8'h77, 4'd5,  4'd6};
        vt[3] = '{8'h1C, 8'h3C, 8'hC3, 4'd12, 4'd13};

        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(2);
        check("rst_sda_t", i2c_sda_t, 1'b1);
        check("rst_sda_o", i2c_sda_o, 1'b0);
        check("rst_scl_o", i2c_scl_o, 1'b0);
        check("rst_scl_t", i2c_scl_t, 1'b1);
        check("rst_regs_nonzero", |regs_flat, 1'b0);
        check("rst_wr_strobe", wr_strobe, 1'b0);
        check("rst_wr_addr", wr_addr, 4'd0);
        check("rst_busy", busy, 1'b0);

        for (int v = 0; v < 4; v++) begin
            base = stb_cnt;
            i2c_start();
            send(8'hA0, "vec_addr_ack");
            check("vec_busy_mid", busy, 1'b1);
            send(vt[v].ptr, "vec_ptr_ack");
            send(vt[v].d0, "vec_d0_ack");
            send(vt[v].d1, "vec_d1_ack");
            i2c_stop();
            check("vec_busy_after_stop", busy, 1'b0);
            check("vec_strobe_count", stb_cnt - base, 2);
            check("vec_wr_addr0", stb_addr[base % 64], vt[v].a0);
            check("vec_wr_addr1", stb_addr[(base + 1) % 64], vt[v].a1);
            check("vec_reg_a0", reg_of(vt[v].a0), vt[v].d0);
            check("vec_reg_a1", reg_of(vt[v].a1), vt[v].d1);
            i2c_start();
            send(8'hA0, "vec_rb_addr_ack");
            send(vt[v].ptr, "vec_rb_ptr_ack");
            i2c_start();
            send(8'hA1, "vec_rb_raddr_ack");
            read_byte(1'b0, r0);
            read_byte(1'b1, r1);
            i2c_stop();
            check("vec_read0", r0, vt[v].d0);
            check("vec_read1", r1, vt[v].d1);
        end

        i2c_start();
        send(8'hA0, "seq_w_addr");
        send(8'h02, "seq_w_ptr");
        send(8'h99, "seq_w_data");
        i2c_stop();
        i2c_start();
        send(8'hA0, "rs_addr");
        send(8'h02, "rs_ptr");
        i2c_start();
        send(8'hA1, "rs_raddr");
        read_byte(1'b0, r0);
        read_byte(1'b0, r1);
        read_byte(1'b1, r2);
        check("rs_busy_before_stop", busy, 1'b1);
        i2c_stop();
        check("rs_busy_after_stop", busy, 1'b0);
        check("rs_read_reg2", r0, 8'h99);
        check("rs_read_reg3", r1, 8'hA5);
        check("rs_read_reg4", r2, 8'h5A);
        i2c_start();
        send(8'hA1, "ptr5_raddr");
        read_byte(1'b1, r0);
        i2c_stop();
        check("ptr5_read", r0, 8'h3E);

        base  = stb_cnt;
        lbase = low_cnt;
        i2c_start();
        write_byte(8'hA2, -1, ack);
        check("bad_addr_nack", ack, 1'b0);
        check("bad_addr_busy", busy, 1'b0);
        write_byte(8'h00, -1, ack);
        check("bad_addr_data_nack", ack, 1'b0);
        i2c_stop();
        check("bad_addr_sda_low_cycles", low_cnt - lbase, 0);
        check("bad_addr_strobes", stb_cnt - base, 0);
        i2c_start();
        send(8'hA0, "after_bad_addr");
        send(8'h0A, "after_bad_ptr");
        send(8'h6B, "after_bad_data");
        i2c_stop();
        check("after_bad_reg10", reg_of(10), 8'h6B);

        base = stb_cnt;
        i2c_start();
        send(8'hA0, "part_addr");
        send(8'h06, "part_ptr");
        for (int i = 0; i < 5; i++) write_bit(1'b1, 1'b0);
        i2c_stop();
        check("part_reg6", reg_of(6), 8'h77);
        check("part_strobes", stb_cnt - base, 0);
        check("part_busy", busy, 1'b0);
        i2c_start();
        send(8'hA1, "part_next_raddr");
        read_byte(1'b1, r0);
        i2c_stop();
        check("part_next_read", r0, 8'h77);

        i2c_start();
        send(8'hA0, "glitch_addr");
        send(8'h07, "glitch_ptr");
        write_byte(8'hC3, 7, ack);
        i2c_stop();
`ifdef I2C_INPUT_FILTER_EN
        check("glitch_reg7", reg_of(7), 8'hC3);
`else
        check("glitch_reg7", reg_of(7), 8'hE1);
`endif

        i2c_start();
        send(8'hA0, "rst_rd_addr");
        send(8'h00, "rst_rd_ptr");
        i2c_start();
        send(8'hA1, "rst_rd_raddr");
        wait_clk(Q);
        check("rst_rd_driving", i2c_sda_t, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_rd_sda_release", i2c_sda_t, 1'b1);
        check("rst_rd_regs_nonzero", |regs_flat, 1'b0);
        check("rst_rd_busy", busy, 1'b0);
        check("rst_rd_wr_addr", wr_addr, 4'd0);
        wait_clk(2);
        rst_n = 1'b1;
        sda_m = 1'b1;
        i2c_stop();
        i2c_start();
        send(8'hA1, "post_rst_raddr");
        read_byte(1'b1, r0);
        i2c_stop();
        check("post_rst_read", r0, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
